// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with registered read, busy rejection and a clear sweep.
// Optional per-word even parity with a par_err output: define RAM_SP_CLR_PARITY_EN.
module ram_sp_clr #(
  parameter int unsigned        DATA_W  = 4,
  parameter int unsigned        ADDR_W  = 4,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cs,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_busy,
  output logic              o_rej
`ifdef RAM_SP_CLR_PARITY_EN
  ,
  output logic              o_par_err
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef RAM_SP_CLR_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] LastPtr = '1;

  typedef enum logic {StClear, StIdle} state_e;

  state_e              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_clr_ptr, w_clr_ptr_d;
  logic [MEM_W-1:0]    r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic                r_rej;
  logic                r_par_err;

  logic                w_busy;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [MEM_W-1:0]    w_mem_wdata;
  logic [MEM_W-1:0]    w_clr_word;
  logic [MEM_W-1:0]    w_wr_word;
  logic [MEM_W-1:0]    w_rd_word;
  logic                w_rd_en;
  logic                w_rej_d;

`ifdef RAM_SP_CLR_PARITY_EN
  assign w_clr_word = {^CLR_VAL, CLR_VAL};
  assign w_wr_word  = {^i_wr_data, i_wr_data};
`else
  assign w_clr_word = CLR_VAL;
  assign w_wr_word  = i_wr_data;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StClear;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_d;
      r_clr_ptr <= w_clr_ptr_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_clr_ptr_d = r_clr_ptr;
    case (r_state)
      StClear: begin
        if (r_clr_ptr == LastPtr) begin
          w_state_d   = StIdle;
          w_clr_ptr_d = '0;
        end else begin
          w_clr_ptr_d = r_clr_ptr + 1'b1;
        end
      end
      StIdle: begin
        if (i_cs && i_clr) w_state_d = StClear;
      end
      default: w_state_d = StClear;
    endcase
  end

  // clr wins over wr/rd in the same cycle; the dropped access does not raise rej.
  always_comb begin
    w_busy      = (r_state == StClear);
    w_mem_we    = 1'b0;
    w_mem_addr  = i_addr;
    w_mem_wdata = w_wr_word;
    if (w_busy) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_clr_ptr;
      w_mem_wdata = w_clr_word;
    end else if (i_cs && !i_clr && i_wr) begin
      w_mem_we = 1'b1;
    end
    w_rd_en = !w_busy && i_cs && !i_clr && i_rd;
    w_rej_d = w_busy && i_cs && (i_wr || i_rd);
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  assign w_rd_word = r_mem[i_addr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rej      <= 1'b0;
      r_par_err  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      r_rej      <= w_rej_d;
      r_par_err  <= w_rd_en ? ^w_rd_word : 1'b0;
      if (w_rd_en) r_rd_data <= w_rd_word[DATA_W-1:0];
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_busy     = w_busy;
  assign o_rej      = r_rej;
`ifdef RAM_SP_CLR_PARITY_EN
  assign o_par_err  = r_par_err;
`endif

endmodule

// File: tb/tb_ram_sp_clr.sv
// Scoreboard bench for ram_sp_clr: stimulus queues expected reads, a monitor checks them.
module tb_ram_sp_clr;

  typedef struct {
    logic [3:0] data;
    logic       par;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_cs = 1'b0, i_wr = 1'b0, i_rd = 1'b0, i_clr = 1'b0;
  logic [3:0] i_addr = '0;
  logic [3:0] i_wr_data = '0;
  logic [3:0] o_rd_data;
  logic       o_rd_valid, o_busy, o_rej;
`ifdef RAM_SP_CLR_PARITY_EN
  logic       o_par_err;
`endif

  int   n_checks = 0;
  int   n_pass = 0;
  int   rej_exp = 0;
  exp_t rd_q[$];

  ram_sp_clr #(.DATA_W(4), .ADDR_W(4), .CLR_VAL(4'h0)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_cs      (i_cs),
    .i_wr      (i_wr),
    .i_rd      (i_rd),
    .i_clr     (i_clr),
    .i_addr    (i_addr),
    .i_wr_data (i_wr_data),
    .o_rd_data (o_rd_data),
    .o_rd_valid(o_rd_valid),
    .o_busy    (o_busy),
    .o_rej     (o_rej)
`ifdef RAM_SP_CLR_PARITY_EN
    ,
    .o_par_err (o_par_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_rd_valid) begin
        if (rd_q.size() == 0) begin
          check("rd_valid_unexpected", o_rd_valid, 1'b0);
        end else begin
          exp_t e;
          e = rd_q.pop_front();
          check("rd_data", o_rd_data, e.data);
`ifdef RAM_SP_CLR_PARITY_EN
          check("par_err", o_par_err, e.par);
`endif
        end
      end
      if (o_rej) begin
        if (rej_exp > 0) begin
          rej_exp--;
          check("rej", o_rej, 1'b1);
        end else begin
          check("rej_unexpected", o_rej, 1'b0);
        end
      end
    end
  end

  // One clock cycle with the given inputs, then inputs return to idle.
  task automatic cyc(input logic cs, input logic wr, input logic rd, input logic clr,
                     input logic [3:0] addr, input logic [3:0] data);
    i_cs = cs; i_wr = wr; i_rd = rd; i_clr = clr; i_addr = addr; i_wr_data = data;
    @(posedge i_clk);
    #1;
    i_cs = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_clr = 1'b0;
  endtask

  task automatic write(input logic [3:0] addr, input logic [3:0] data);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, addr, data);
  endtask

  task automatic read(input logic [3:0] addr, input logic [3:0] exp, input logic par);
    exp_t e;
    e.data = exp;
    e.par  = par;
    rd_q.push_back(e);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, addr, 4'h0);
    check("rd_latency", o_rd_valid, 1'b1);
  endtask

  // Counts clock edges until busy drops, bounded so the bench cannot hang.
  task automatic wait_idle(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
      if (!o_busy) break;
    end
  endtask

  int n;

  initial begin
    #3;
    check("reset_busy", o_busy, 1'b1);
    check("reset_rd_valid", o_rd_valid, 1'b0);
    check("reset_rd_data", o_rd_data, 4'h0);
    check("reset_rej", o_rej, 1'b0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    wait_idle(n);
    check("init_sweep_cycles", n, 16);

    for (int a = 0; a < 16; a++) read(4'(a), 4'h0, 1'b0);

    write(4'd1, 4'hA);
    write(4'd9, 4'h5);
    read(4'd1, 4'hA, 1'b0);
    read(4'd9, 4'h5, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0);
    check("rd_data_hold", o_rd_data, 4'h5);
    check("rd_valid_low", o_rd_valid, 1'b0);

    // Read-first on simultaneous wr/rd to the same address.
    rd_q.push_back('{data: 4'h0, par: 1'b0});
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 4'hC);
    check("rdwr_latency", o_rd_valid, 1'b1);
    read(4'd3, 4'hC, 1'b0);

    // clr with a concurrent wr: no rej; then wr and rd while busy are rejected.
    write(4'd2, 4'h7);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 4'hF);
    check("clr_busy", o_busy, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0);
    rej_exp++;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 4'hF);
    rej_exp++;
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 4'h0);
    wait_idle(n);
    check("clr_sweep_remaining", n, 13);
    check("rej_all_seen", rej_exp, 0);
    read(4'd2, 4'h0, 1'b0);
    read(4'd1, 4'h0, 1'b0);

    // cs=0 blocks both write and clr.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 4'h9);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 4'h0);
    check("cs0_clr_ignored", o_busy, 1'b0);
    read(4'd4, 4'h0, 1'b0);

    // Reset in sweep cycle 5 restarts a full sweep; last address must be cleared.
    write(4'd15, 4'hE);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'h0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0);
    i_rst_n = 1'b0;
    #2;
    check("midreset_busy", o_busy, 1'b1);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    wait_idle(n);
    check("midreset_sweep_cycles", n, 16);
    read(4'd15, 4'h0, 1'b0);

`ifdef RAM_SP_CLR_PARITY_EN
    write(4'd6, 4'hB);
    read(4'd6, 4'hB, 1'b0);
    dut.r_mem[6][0] = ~dut.r_mem[6][0];
    read(4'd6, 4'hA, 1'b1);
`endif

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0);
    check("scoreboard_drained", rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
